// File: rtl/mac_dot_engine_if.sv
// Operand/result stream bundle for mac_dot_engine: run control, operand handshake, result handshake.
interface mac_dot_engine_if #(
    parameter int unsigned BITS     = 24,
    parameter int unsigned ACC_BITS = 2 * BITS + 8,
    parameter int unsigned LEN_BITS = 8
);
    logic                start;
    logic [LEN_BITS-1:0] len;
    logic                signed_mode;
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     element_i;
    logic [BITS-1:0]     element_j;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_BITS-1:0] result;
    logic                overflow;
    logic                busy;

    modport master (
        output start, len, signed_mode, in_valid, element_i, element_j, out_ready,
        input  in_ready, out_valid, result, overflow, busy
    );

    modport slave (
        input  start, len, signed_mode, in_valid, element_i, element_j, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );
endinterface

// File: rtl/mac_dot_engine.sv
// Streaming dot-product engine: operand register -> multiply -> accumulate, fixed 3-cycle drain.
// Result and overflow hold after the output handshake until the next start.
module mac_dot_engine #(
    parameter int unsigned BITS     = 24,
    parameter int unsigned ACC_BITS = 2 * BITS + 8,
    parameter int unsigned LEN_BITS = 8,
    parameter bit          SATURATE = 1'b1
) (
    input logic             clk,
    input logic             reset,
    mac_dot_engine_if.slave bus
);
    localparam int unsigned PW = 2 * BITS;

    if (ACC_BITS < PW) begin : g_acc_bits_check
        $error("mac_dot_engine: ACC_BITS must be >= 2*BITS");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [LEN_BITS-1:0] rem_q, rem_d;
    logic                smode_q, smode_d;
    logic [BITS-1:0]     op_a_q, op_b_q;
    logic                op_v_q;
    logic [PW-1:0]       prod_q;
    logic                prod_v_q;
    logic [ACC_BITS-1:0] acc_q, acc_next;
    logic                ovf_q;

    logic                accept, clear, in_ready;
    logic signed [BITS:0] a_ext, b_ext;
    logic [ACC_BITS:0]   prod_ext, acc_ext, sum;
    logic                sum_ovf;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        smode_d  = smode_q;
        clear    = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    smode_d = bus.signed_mode;
                    clear   = 1'b1;
                    if (bus.len != '0) begin
                        rem_d   = bus.len;
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_BITS'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!op_v_q && !prod_v_q) state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    // One extra bit on each operand lets a single signed multiplier serve both modes.
    always_comb begin
        a_ext = $signed({smode_q & op_a_q[BITS-1], op_a_q});
        b_ext = $signed({smode_q & op_b_q[BITS-1], op_b_q});
    end

    always_comb begin
        prod_ext = {{(ACC_BITS + 1 - PW){smode_q & prod_q[PW-1]}}, prod_q};
        acc_ext  = {smode_q & acc_q[ACC_BITS-1], acc_q};
        sum      = acc_ext + prod_ext;
        sum_ovf  = smode_q ? (sum[ACC_BITS] != sum[ACC_BITS-1]) : sum[ACC_BITS];
        acc_next = sum[ACC_BITS-1:0];
        if (sum_ovf && SATURATE) begin
            if (!smode_q) begin
                acc_next = '1;
            end else if (sum[ACC_BITS]) begin
                acc_next = {1'b1, {(ACC_BITS - 1){1'b0}}};
            end else begin
                acc_next = {1'b0, {(ACC_BITS - 1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            smode_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_v_q   <= 1'b0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            smode_q  <= smode_d;
            op_v_q   <= accept;
            prod_v_q <= op_v_q;
            if (accept) begin
                op_a_q <= bus.element_i;
                op_b_q <= bus.element_j;
            end
            if (op_v_q) prod_q <= PW'(a_ext * b_ext);
            if (clear) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (prod_v_q) begin
                acc_q <= acc_next;
                if (sum_ovf) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = acc_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_mac_dot_engine.sv
// Self-checking bench: saturating and wrapping engines driven in lockstep against an
// arithmetic reference model.
module tb_mac_dot_engine;
    localparam int unsigned BITS     = 8;
    localparam int unsigned ACC_BITS = 16;
    localparam int unsigned LEN_BITS = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                start, signed_mode, in_valid, out_ready;
    logic [LEN_BITS-1:0] len;
    logic [BITS-1:0]     ei, ej;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    mac_dot_engine_if #(.BITS(BITS), .ACC_BITS(ACC_BITS), .LEN_BITS(LEN_BITS)) bs ();
    mac_dot_engine_if #(.BITS(BITS), .ACC_BITS(ACC_BITS), .LEN_BITS(LEN_BITS)) bw ();

    assign bs.start = start;         assign bw.start = start;
    assign bs.len = len;             assign bw.len = len;
    assign bs.signed_mode = signed_mode; assign bw.signed_mode = signed_mode;
    assign bs.in_valid = in_valid;   assign bw.in_valid = in_valid;
    assign bs.element_i = ei;        assign bw.element_i = ei;
    assign bs.element_j = ej;        assign bw.element_j = ej;
    assign bs.out_ready = out_ready; assign bw.out_ready = out_ready;

    mac_dot_engine #(
        .BITS(BITS), .ACC_BITS(ACC_BITS), .LEN_BITS(LEN_BITS), .SATURATE(1'b1)
    ) dut_sat (
        .clk(clk), .reset(reset), .bus(bs)
    );

    mac_dot_engine #(
        .BITS(BITS), .ACC_BITS(ACC_BITS), .LEN_BITS(LEN_BITS), .SATURATE(1'b0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .bus(bw)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Dot product over qa/qb with a 16-bit accumulator, evaluated pair by pair.
    function automatic void model(input bit sm, input bit sat, output logic [15:0] res,
                                  output logic ov);
        longint acc, a, b, s;
        acc = 0;
        ov  = 1'b0;
        foreach (qa[k]) begin
            a = sm ? longint'($signed(qa[k])) : longint'(qa[k]);
            b = sm ? longint'($signed(qb[k])) : longint'(qb[k]);
            s = acc + a * b;
            if (sm && s > 32767) begin
                ov  = 1'b1;
                acc = sat ? 32767 : s - 65536;
            end else if (sm && s < -32768) begin
                ov  = 1'b1;
                acc = sat ? -32768 : s + 65536;
            end else if (!sm && s > 65535) begin
                ov  = 1'b1;
                acc = sat ? 65535 : s - 65536;
            end else begin
                acc = s;
            end
        end
        res = acc[15:0];
    endfunction

    // gap < 0 selects random 0..2 idle cycles before each pair.
    task automatic run(input string tag, input bit sm, input int gap, input int hold,
                       input bit start_on_hs);
        logic [15:0] es, ew;
        logic        os, ow;
        int          k, guard, lat, g;
        bit          hs;
        model(sm, 1'b1, es, os);
        model(sm, 1'b0, ew, ow);
        start = 1'b1;
        len = LEN_BITS'(qa.size());
        signed_mode = sm;
        tick();
        start = 1'b0;
        check({tag, "/busy_run"}, bs.busy, 1);
        check({tag, "/in_ready_run"}, bs.in_ready, 1);
        len = 8'($urandom);
        signed_mode = ~sm;
        k = 0;
        guard = 0;
        while (k < qa.size() && guard < 1000) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            repeat (g) begin
                in_valid = 1'b0;
                ei = 8'($urandom);
                ej = 8'($urandom);
                start = ($urandom_range(0, 1) == 1);
                tick();
            end
            in_valid = 1'b1;
            ei = qa[k];
            ej = qb[k];
            start = 1'b0;
            hs = bs.in_ready;
            tick();
            guard++;
            if (hs) k++;
        end
        in_valid = 1'b0;
        check({tag, "/accepted"}, k, qa.size());
        check({tag, "/in_ready_drain"}, bs.in_ready, 0);
        check({tag, "/out_valid_drain"}, bs.out_valid, 0);
        lat = 0;
        while (bs.out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, lat, 3);
        check({tag, "/result_sat"}, bs.result, es);
        check({tag, "/ovf_sat"}, bs.overflow, os);
        check({tag, "/result_wrap"}, bw.result, ew);
        check({tag, "/ovf_wrap"}, bw.overflow, ow);
        out_ready = 1'b0;
        repeat (hold) begin
            start = 1'b1;
            tick();
            check({tag, "/hold_valid"}, bs.out_valid, 1);
            check({tag, "/hold_result"}, bs.result, es);
        end
        start = start_on_hs;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        check({tag, "/post_valid"}, bs.out_valid, 0);
        check({tag, "/post_busy"}, bs.busy, 0);
        check({tag, "/post_result"}, bs.result, es);
        check({tag, "/post_ovf"}, bs.overflow, os);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        len = '0;
        signed_mode = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ei = '0;
        ej = '0;
        tick();
        check("reset/in_ready", bs.in_ready, 0);
        check("reset/out_valid", bs.out_valid, 0);
        check("reset/result", bs.result, 0);
        check("reset/overflow", bs.overflow, 0);
        check("reset/busy", bs.busy, 0);
        tick();
        reset = 1'b0;
        tick();

        qa = {8'd2, 8'hFC, 8'd7};
        qb = {8'd3, 8'd5, 8'hFF};
        run("signed3", 1'b1, 0, 0, 1'b0);
        check("signed3/const", bs.result, 16'hFFEB);

        qa = {8'd255, 8'd1};
        qb = {8'd255, 8'd1};
        run("unsigned_gap", 1'b0, 2, 0, 1'b0);
        check("unsigned_gap/const", bs.result, 65026);

        qa = {8'h80, 8'h80, 8'h80, 8'h80};
        qb = {8'h80, 8'h80, 8'h80, 8'h80};
        run("sat", 1'b1, 0, 1, 1'b1);
        check("sat/const_sat", bs.result, 32767);
        check("sat/const_ovf_sat", bs.overflow, 1);
        check("sat/const_wrap", bw.result, 0);
        check("sat/const_ovf_wrap", bw.overflow, 1);

        start = 1'b1;
        len = 8'd0;
        signed_mode = 1'b1;
        tick();
        start = 1'b0;
        check("len0/out_valid", bs.out_valid, 1);
        check("len0/in_ready", bs.in_ready, 0);
        check("len0/result", bs.result, 0);
        check("len0/overflow", bs.overflow, 0);
        repeat (5) begin
            tick();
            check("len0/hold_valid", bs.out_valid, 1);
            check("len0/hold_result", bs.result, 0);
            check("len0/hold_in_ready", bs.in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("len0/busy_after", bs.busy, 0);
        check("len0/valid_after", bs.out_valid, 0);

        start = 1'b1;
        len = 8'd4;
        signed_mode = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        ei = 8'd5;
        ej = 8'd5;
        tick();
        ei = 8'd6;
        ej = 8'd6;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("abort/partial", bs.result, 61);
        check("abort/busy_before", bs.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort/result", bs.result, 0);
        check("abort/busy", bs.busy, 0);
        check("abort/in_ready", bs.in_ready, 0);
        check("abort/out_valid", bs.out_valid, 0);
        check("abort/overflow", bs.overflow, 0);
        tick();
        reset = 1'b0;
        tick();
        qa = {8'd3};
        qb = {8'd4};
        run("after_abort", 1'b0, 0, 0, 1'b0);
        check("after_abort/const", bs.result, 12);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 12);
            qa.delete();
            qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(8'($urandom));
                qb.push_back(8'($urandom));
            end
            run($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1), -1,
                $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_dot_engine.md
Name: mac_dot_engine

Overview:
- Parametrised successor to the single-shot MAC core: a pipelined, streaming dot-product engine.
- Accepts a run-time-programmed number of operand pairs over a valid/ready stream and accumulates their products internally.
- Supports signed or unsigned operands and optional saturation.
- Presents one result over a valid/ready output. Used as the per-cell compute element of the matrix multiplier.

Parameters:
- BITS, 24, operand width.
- ACC_BITS, 2*BITS+8, accumulator/result width. Must be >= 2*BITS; elaboration error otherwise.
- LEN_BITS, 8, width of the vector-length field.
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  begins a run; sampled only in IDLE.
- len  in  LEN_BITS  number of operand pairs in the run; sampled with start.
- signed_mode  in  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine accepts the operand pair.
- element_i  in  BITS  first operand.
- element_j  in  BITS  second operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  ACC_BITS  accumulated dot product.
- overflow  out  1  sticky flag: clamp/wrap occurred during the current run.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; all registers cleared.
  - in_ready = 0, out_valid = 0, result = 0, overflow = 0, busy = 0.
  - Reset asserted mid-run aborts the run. The partial result is discarded and not emitted.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready = 0.
  - start=1 with len != 0: latch len into remaining count, latch signed_mode, clear acc and overflow, go to RUN.
  - start=1 with len == 0: clear acc and overflow, go directly to DONE (result = 0).
- RUN:
  - in_ready = 1.
  - Each handshake (in_valid & in_ready) captures the pair and decrements the remaining count.
  - in_valid gaps are allowed; the count does not change on idle cycles.
  - The handshake that takes remaining from 1 to 0 moves the state to DRAIN.
- Pipeline:
  - Operands are registered in the accept cycle.
  - Stage 1 (next edge): 2*BITS product, sign- or zero-extended per the latched mode.
  - Stage 2 (following edge): acc <= acc + product.
  - Each stage carries a valid bit; bubbles do not touch acc.
- DRAIN:
  - in_ready = 0.
  - Leave for DONE when both stage valids are 0.
- Latency: last pair accepted at edge E0 -> product at E1 -> acc at E2 -> out_valid = 1 after E3. Fixed at 3 cycles; gaps in in_valid do not change it.
- DONE:
  - out_valid = 1; result = acc.
  - result and overflow stay stable while out_ready = 0.
  - The out_valid & out_ready handshake moves the state to IDLE. out_valid drops on the next edge; result and overflow hold their values until the next start.
- start is ignored in RUN, DRAIN and DONE. start in the same cycle as the DONE handshake is also ignored; it is taken only from IDLE.
- Arithmetic:
  - The sum is computed ACC_BITS+1 wide.
  - Signed overflow: sign of the extended sum differs from bit ACC_BITS-1.
  - Unsigned overflow: carry-out set.
  - On overflow, overflow <= 1 (sticky until the next start).
  - SATURATE=1: acc clamps to 2^(ACC_BITS-1)-1 or -2^(ACC_BITS-1) (signed), or to 2^ACC_BITS-1 (unsigned). A saturated acc continues accumulating from the clamped value.
  - SATURATE=0: acc takes the low ACC_BITS bits.
- len is latched once per run; changes to len during RUN have no effect.

Test Plan:
- BITS=8, signed, len=3, pairs (2,3),(-4,5),(7,-1) with no gaps, out_ready=1 -> result=-21, overflow=0, out_valid exactly 3 cycles after the last accept.
- BITS=8, unsigned, len=2, pairs (255,255),(1,1) with 2-cycle in_valid gaps -> result=65026, overflow=0, same 3-cycle latency after the last accept.
- BITS=8, ACC_BITS=16, SATURATE=1, signed, len=4, all pairs (-128,-128) -> result=32767, overflow=1. With SATURATE=0 -> result=0, overflow=1.
- len=0 with start -> DONE with no in_ready pulse, result=0. Hold out_ready=0 for 5 cycles -> out_valid and result stable; accept -> busy=0 next cycle.
- Reset asserted mid-RUN after 2 of 4 pairs -> outputs 0 immediately (async); a new run len=1 (3,4) -> result=12 with no residue from the aborted run.
- start pulsed during RUN and DONE -> ignored. len changed mid-run -> the original count is still honoured.
